// File: rtl/frame_config_writer.sv
// frame_config_writer
//   Configuration-side driver of the fabric frame protocol. Consumes a word stream
//   (header, then one data word per fabric row), loads the row FrameData registers
//   and fires a single-cycle one-hot FrameStrobe for the addressed column/frame.
//
// Ports
//   CLK          clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   s_data       stream word (header or row data)
//   s_valid      s_data valid
//   s_ready      writer can accept; a word transfers when s_valid && s_ready
//   FrameData    row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  column c occupies bits [c*MaxFramesPerCol +: MaxFramesPerCol]
//   busy         high whenever the writer is not idle
//   err          sticky header error, cleared only by reset
//   frame_count  number of frames strobed, wraps at 16 bits
//
// Header word: [31:24] sync 8'hFA, [23:16] reserved, [15:8] column, [7:0] frame.
module frame_config_writer #(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumRows         = 16,
    parameter int unsigned NumCols         = 16
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic [FrameBitsPerRow-1:0]           s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]   FrameStrobe,
    output logic                                 busy,
    output logic                                 err,
    output logic [15:0]                          frame_count
);

    localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned StrobeW = NumCols * MaxFramesPerCol;
    localparam int unsigned DataW   = NumRows * FrameBitsPerRow;

    localparam logic [RowW-1:0]    LastRow   = RowW'(NumRows - 1);
    localparam logic [StrobeW-1:0] StrobeOne = StrobeW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStrobe
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           col_q, col_d;
    logic [7:0]           frame_q, frame_d;
    logic [RowW-1:0]      row_q, row_d;
    logic [DataW-1:0]     data_q, data_d;
    logic [StrobeW-1:0]   strobe_q, strobe_d;
    logic                 err_q, err_d;
    logic [15:0]          frame_count_q, frame_count_d;

    logic                 xfer;
    logic                 hdr_ok;

    always_comb begin
        // Ready is forced low while reset is asserted so nothing is consumed then.
        s_ready = !reset && (state_q != StStrobe);
        xfer    = s_valid && s_ready;

        // Full 8-bit unsigned compares: out-of-range fields are errors, never truncated.
        hdr_ok = (s_data[31:24] == 8'hFA)
              && (32'(s_data[15:8]) < NumCols)
              && (32'(s_data[7:0]) < MaxFramesPerCol);

        state_d       = state_q;
        col_d         = col_q;
        frame_d       = frame_q;
        row_d         = row_q;
        data_d        = data_q;
        err_d         = err_q;
        frame_count_d = frame_count_q + 16'd1;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (hdr_ok) begin
                        col_d   = s_data[15:8];
                        frame_d = s_data[7:0];
                        row_d   = '0;
                        state_d = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (xfer) begin
                    data_d[32'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                    row_d = row_q + RowW'(1);
                    if (row_q == LastRow) begin
                        state_d = StStrobe;
                    end
                end
            end
            StStrobe: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Strobe is registered alongside the state so it is high exactly in StStrobe.
        if (state_d == StStrobe) begin
            strobe_d = StrobeOne << (32'(col_q) * MaxFramesPerCol + 32'(frame_q));
        end else begin
            strobe_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= StIdle;
            col_q         <= '0;
            frame_q       <= '0;
            row_q         <= '0;
            data_q        <= '0;
            strobe_q      <= '0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            row_q    <= row_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            if (state_q == StStrobe) begin
                frame_count_q <= frame_count_d;
            end
        end
    end

    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign busy        = (state_q != StIdle);
    assign err         = err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// tb_frame_config_writer
//   Self-checking bench for frame_config_writer. A transaction-level model keeps the
//   expected row contents, frame count and error flag; a monitor logs every cycle in
//   which FrameStrobe is non-zero (bit index and cycle number) for the tests to check.
//
// Cycle numbering: cyc increments on each rising edge and is read on falling edges.
// A handshake recorded with value c means the word was taken on the edge that made
// cyc equal c; a strobe logged with value c was visible during that same cycle.
module tb_frame_config_writer;

    localparam int W  = 32;
    localparam int MF = 20;
    localparam int NR = 16;
    localparam int NC = 16;

    logic                 CLK = 1'b0;
    logic                 reset;
    logic [W-1:0]         s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [NR*W-1:0]      FrameData;
    logic [NC*MF-1:0]     FrameStrobe;
    logic                 busy;
    logic                 err;
    logic [15:0]          frame_count;

    frame_config_writer #(
        .FrameBitsPerRow (W),
        .MaxFramesPerCol (MF),
        .NumRows         (NR),
        .NumCols         (NC)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .err         (err),
        .frame_count (frame_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [W-1:0] exp_rows [NR];
    logic [15:0]  exp_count;
    logic         exp_err;

    // Strobe monitor
    int strb_idx [$];
    int strb_cyc [$];
    int multi_hot      = 0;
    int ready_in_strbe = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            if ($countones(FrameStrobe) != 1) multi_hot++;
            if (s_ready !== 1'b0) ready_in_strbe++;
            for (int i = 0; i < NC*MF; i++) begin
                if (FrameStrobe[i]) begin
                    strb_idx.push_back(i);
                    strb_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t want < 2000000", $time);
        $fatal(1);
    end

    function automatic int rows_bad();
        int n = 0;
        for (int r = 0; r < NR; r++) begin
            if (FrameData[r*W +: W] !== exp_rows[r]) n++;
        end
        return n;
    endfunction

    // All stimulus tasks start and end on a falling edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b1;
        s_valid = 1'b0;
        cycles(n);
        reset = 1'b0;
        for (int r = 0; r < NR; r++) exp_rows[r] = '0;
        exp_count = 16'd0;
        exp_err   = 1'b0;
    endtask

    // Present one word after up to gap idle cycles; hc = handshake cycle number.
    task automatic send(input logic [W-1:0] w, input int gap, output int hc);
        logic rdy;
        bit   done;
        int   g;
        done = 0;
        hc   = -1;
        g    = (gap > 0) ? $urandom_range(0, gap) : 0;
        s_valid = 1'b0;
        cycles(g);
        s_valid = 1'b1;
        s_data  = w;
        for (int t = 0; t < 100 && !done; t++) begin
            #1 rdy = s_ready;
            @(posedge CLK);
            @(negedge CLK);
            if (rdy) begin
                done = 1;
                hc   = cyc;
            end
        end
        s_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted, got 0 handshakes want 1", w);
        end
    endtask

    // Header with no leading gap, then NR data words (fixed pattern or random).
    task automatic send_frame(input int col, input int fr, input int gap, input bit fixed,
                              output int hdr_c, output int last_c);
        logic [W-1:0] w;
        int           c;
        send({8'hFA, 8'($urandom), 8'(col), 8'(fr)}, 0, hdr_c);
        for (int r = 0; r < NR; r++) begin
            w = fixed ? (32'h1000_0000 + 32'(r)) : 32'($urandom);
            send(w, gap, c);
            exp_rows[r] = w;
        end
        last_c    = c;
        exp_count = exp_count + 16'd1;
    endtask

    task automatic test_reset();
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b want 0", s_ready);
        end
        do_reset(2);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: got %b want 1", s_ready);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || frame_count !== 16'd0 || FrameStrobe !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b err=%b count=%h strobe_zero=%b want 0 0 0000 1",
                     busy, err, frame_count, FrameStrobe == '0);
        end
        checks++;
        if (rows_bad() !== 0) begin
            errors++;
            $display("FAIL reset_framedata: got %0d nonzero rows want 0", rows_bad());
        end
        @(negedge CLK);
    endtask

    task automatic test_basic();
        int hc, lc;
        strb_idx.delete();
        strb_cyc.delete();
        send_frame(3, 5, 0, 1'b1, hc, lc);
        cycles(3);
        checks++;
        if (strb_idx.size() !== 1) begin
            errors++;
            $display("FAIL basic_strobe_count: got %0d strobe cycles want 1", strb_idx.size());
        end else begin
            checks++;
            if (strb_idx[0] !== 65) begin
                errors++;
                $display("FAIL basic_strobe_bit: got %0d want 65", strb_idx[0]);
            end
            checks++;
            if (strb_cyc[0] !== hc + NR) begin
                errors++;
                $display("FAIL basic_strobe_latency: got %0d want %0d", strb_cyc[0] - hc, NR);
            end
        end
        checks++;
        if (rows_bad() !== 0) begin
            errors++;
            $display("FAIL basic_rows: got %0d bad rows want 0", rows_bad());
        end
        checks++;
        if (frame_count !== exp_count || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got count=%h busy=%b err=%b want %h 0 0",
                     frame_count, busy, err, exp_count);
        end
    endtask

    task automatic test_bad_headers();
        int hc, lc;
        strb_idx.delete();
        strb_cyc.delete();
        send(32'hFA00_1000, 0, hc);
        exp_err = 1'b1;
        checks++;
        if (err !== exp_err || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_column: got err=%b busy=%b want 1 0", err, busy);
        end
        send(32'hAB00_0000, 0, hc);
        cycles(3);
        checks++;
        if (err !== exp_err || busy !== 1'b0 || strb_idx.size() !== 0) begin
            errors++;
            $display("FAIL bad_sync: got err=%b busy=%b strobes=%0d want 1 0 0",
                     err, busy, strb_idx.size());
        end
        send_frame(0, 0, 1, 1'b0, hc, lc);
        cycles(3);
        checks++;
        if (strb_idx.size() !== 1 || (strb_idx.size() == 1 && strb_idx[0] !== 0)) begin
            errors++;
            $display("FAIL after_err_frame: got %0d strobes want 1 at bit 0", strb_idx.size());
        end
        checks++;
        if (err !== 1'b1 || rows_bad() !== 0 || frame_count !== exp_count) begin
            errors++;
            $display("FAIL after_err_state: got err=%b badrows=%0d count=%h want 1 0 %h",
                     err, rows_bad(), frame_count, exp_count);
        end
    endtask

    task automatic test_boundary();
        int hc, lc;
        do_reset(1);
        strb_idx.delete();
        strb_cyc.delete();
        send_frame(NC-1, MF-1, 1, 1'b0, hc, lc);
        cycles(3);
        checks++;
        if (strb_idx.size() !== 1 || (strb_idx.size() == 1 && strb_idx[0] !== 319)) begin
            errors++;
            $display("FAIL boundary_strobe: got count=%0d want 1 strobe at bit 319", strb_idx.size());
        end
        checks++;
        if (err !== 1'b0 || rows_bad() !== 0) begin
            errors++;
            $display("FAIL boundary_valid: got err=%b badrows=%0d want 0 0", err, rows_bad());
        end
        send(32'hFA00_0F14, 0, hc);
        cycles(3);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || strb_idx.size() !== 1) begin
            errors++;
            $display("FAIL boundary_frame20: got err=%b busy=%b strobes=%0d want 1 0 1",
                     err, busy, strb_idx.size());
        end
    endtask

    task automatic test_back_to_back();
        int hc [6];
        int lc [6];
        int ei [6];
        int col, fr;
        strb_idx.delete();
        strb_cyc.delete();
        for (int k = 0; k < 6; k++) begin
            col   = $urandom_range(0, NC-1);
            fr    = $urandom_range(0, MF-1);
            ei[k] = col * MF + fr;
            send_frame(col, fr, (k < 3) ? 3 : 0, 1'b0, hc[k], lc[k]);
        end
        cycles(3);
        checks++;
        if (strb_idx.size() !== 6) begin
            errors++;
            $display("FAIL b2b_strobe_count: got %0d want 6", strb_idx.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (strb_idx[k] !== ei[k] || strb_cyc[k] !== lc[k]) begin
                    errors++;
                    $display("FAIL b2b_strobe%0d: got bit %0d cyc %0d want bit %0d cyc %0d",
                             k, strb_idx[k], strb_cyc[k], ei[k], lc[k]);
                end
            end
        end
        for (int k = 1; k < 6; k++) begin
            checks++;
            if (hc[k] !== lc[k-1] + 2) begin
                errors++;
                $display("FAIL b2b_queued_hdr%0d: got accept %0d cycles after last data want 2",
                         k, hc[k] - lc[k-1]);
            end
        end
        for (int k = 4; k < 6; k++) begin
            checks++;
            if (hc[k] - hc[k-1] !== NR + 2) begin
                errors++;
                $display("FAIL b2b_period%0d: got %0d want %0d", k, hc[k] - hc[k-1], NR + 2);
            end
        end
        checks++;
        if (rows_bad() !== 0 || frame_count !== exp_count) begin
            errors++;
            $display("FAIL b2b_state: got badrows=%0d count=%h want 0 %h",
                     rows_bad(), frame_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_load();
        int hc, lc;
        strb_idx.delete();
        strb_cyc.delete();
        send(32'hFA00_0204, 0, hc);
        for (int r = 0; r < 7; r++) send(32'($urandom), 1, hc);
        do_reset(1);
        #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midload_ready: got ready=%b busy=%b want 1 0", s_ready, busy);
        end
        @(negedge CLK);
        cycles(20);
        checks++;
        if (strb_idx.size() !== 0 || rows_bad() !== 0 || frame_count !== exp_count) begin
            errors++;
            $display("FAIL midload_abort: got strobes=%0d badrows=%0d count=%h want 0 0 %h",
                     strb_idx.size(), rows_bad(), frame_count, exp_count);
        end
        send_frame(7, 11, 2, 1'b0, hc, lc);
        cycles(3);
        checks++;
        if (strb_idx.size() !== 1 || (strb_idx.size() == 1 && strb_idx[0] !== 7*MF + 11)
            || rows_bad() !== 0 || frame_count !== exp_count) begin
            errors++;
            $display("FAIL midload_recover: got strobes=%0d badrows=%0d count=%h want 1 0 %h",
                     strb_idx.size(), rows_bad(), frame_count, exp_count);
        end
    endtask

    task automatic test_count_wrap();
        int hc, lc;
        strb_idx.delete();
        strb_cyc.delete();
        force dut.frame_count_q = 16'hFFFF;
        cycles(1);
        release dut.frame_count_q;
        exp_count = 16'hFFFF;
        cycles(1);
        checks++;
        if (frame_count !== exp_count) begin
            errors++;
            $display("FAIL wrap_preload: got %h want %h", frame_count, exp_count);
        end
        send_frame(1, 2, 0, 1'b0, hc, lc);
        cycles(2);
        checks++;
        if (frame_count !== exp_count || strb_idx.size() !== 1) begin
            errors++;
            $display("FAIL wrap_rollover: got count=%h strobes=%0d want %h 1",
                     frame_count, strb_idx.size(), exp_count);
        end
    endtask

    task automatic test_strobe_onehot();
        checks++;
        if (multi_hot !== 0 || ready_in_strbe !== 0) begin
            errors++;
            $display("FAIL strobe_onehot_ready: got multihot=%0d ready_high=%0d want 0 0",
                     multi_hot, ready_in_strbe);
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        @(negedge CLK);
        test_reset();
        test_basic();
        test_bad_headers();
        test_boundary();
        test_back_to_back();
        test_reset_mid_load();
        test_count_wrap();
        test_strobe_onehot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
